// File: rtl/reg_write_select.sv
// reg_write_select: registered 5-to-32 one-hot write-select decoder.
// A 2:4 stage on address bits [4:3], gated by RegWrite, enables one of four
// 3:8 stages on bits [2:0]. The result is registered once for writeback.
// Optional build macro: REG_WRITE_SELECT_XZR_MASK_EN -- when defined,
// register 31 (XZR) never produces a select.
`timescale 1ns/1ps

module decoder2_4 (
    input  logic       i0,
    input  logic       i1,
    input  logic       enable,
    output logic [3:0] out
);
    // Gated one-hot decode of {i0,i1}; enable low forces all zeros.
    assign out = enable ? (4'b0001 << {i0, i1}) : 4'b0000;
endmodule

module decoder3_8 (
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       enable,
    output logic [7:0] out
);
    // Gated one-hot decode of {i0,i1,i2}; enable low forces all zeros.
    assign out = enable ? (8'b0000_0001 << {i0, i1, i2}) : 8'b0000_0000;
endmodule

module reg_write_select (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  WriteRegister,
    input  logic        RegWrite,
    output logic [31:0] selectReg,
    output logic [31:0] selectComb
);
    // Bit 31 is dropped in the XZR-masked build; every other bit is kept.
`ifdef REG_WRITE_SELECT_XZR_MASK_EN
    localparam logic [31:0] XzrMask = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] XzrMask = 32'hFFFF_FFFF;
`endif

    logic [3:0]  selectDec;
    logic [31:0] decodeRaw;

    // Upper address bits pick the bank; RegWrite gates the whole tree here,
    // so a disabled write can never reach any 3:8 stage.
    decoder2_4 uDecHi (
        .i0     (WriteRegister[4]),
        .i1     (WriteRegister[3]),
        .enable (RegWrite),
        .out    (selectDec)
    );

    // One 3:8 stage per bank of eight registers.
    for (genvar j = 0; j < 4; j++) begin : gBank
        decoder3_8 uDecLo (
            .i0     (WriteRegister[2]),
            .i1     (WriteRegister[1]),
            .i2     (WriteRegister[0]),
            .enable (selectDec[j]),
            .out    (decodeRaw[8*j +: 8])
        );
    end

    assign selectComb = decodeRaw & XzrMask;

    // Register the decode; reset clears immediately and drops any pending select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) selectReg <= 32'h0000_0000;
        else          selectReg <= selectComb;
    end
endmodule

// File: tb/tb_reg_write_select.sv
// Self-checking bench for reg_write_select and its decoder submodules.
`timescale 1ns/1ps

module tb_reg_write_select;
    logic        clk;
    logic        reset_n;
    logic [4:0]  WriteRegister;
    logic        RegWrite;
    logic [31:0] selectReg;
    logic [31:0] selectComb;

    logic       d24I0, d24I1, d24En;
    logic [3:0] d24Out;
    logic       d38I0, d38I1, d38I2, d38En;
    logic [7:0] d38Out;

    int errors = 0;
    int checks = 0;

`ifdef REG_WRITE_SELECT_XZR_MASK_EN
    localparam bit XzrMasked = 1'b1;
`else
    localparam bit XzrMasked = 1'b0;
`endif

    reg_write_select dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .selectReg     (selectReg),
        .selectComb    (selectComb)
    );

    decoder2_4 uD24 (.i0(d24I0), .i1(d24I1), .enable(d24En), .out(d24Out));
    decoder3_8 uD38 (.i0(d38I0), .i1(d38I1), .i2(d38I2), .enable(d38En), .out(d38Out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what register should be written, as a 32-bit select word.
    function automatic logic [31:0] refSel(input logic we, input logic [4:0] addr);
        if (!we) return 32'h0;
        if (XzrMasked && addr == 5'd31) return 32'h0;
        return 32'h1 << addr;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] expPrev;
        logic        prevWe;
        logic [4:0]  prevAddr;

        // Reset held with a live write request.
        reset_n = 1'b0;
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        {d24I0, d24I1, d24En} = 3'b000;
        {d38I0, d38I1, d38I2, d38En} = 4'b0000;
        #2;
        check("reset_hold_t0", selectReg, 32'h0);
        check("comb_during_reset", selectComb, 32'h0000_0020);
        tick();
        check("reset_hold_edge1", selectReg, 32'h0);
        tick();
        check("reset_hold_edge2", selectReg, 32'h0);
        reset_n = 1'b1;
        tick();
        check("reset_release", selectReg, 32'h0000_0020);

        // Disabled sweep: nothing may ever select.
        for (int n = 0; n < 32; n++) begin
            RegWrite = 1'b0;
            WriteRegister = 5'(n);
            #1;
            check($sformatf("dis_comb_%0d", n), selectComb, 32'h0);
            tick();
            check($sformatf("dis_reg_%0d", n), selectReg, 32'h0);
        end

        // Enabled sweep with an async reset pulse between edges at n=12.
        for (int n = 0; n < 32; n++) begin
            RegWrite = 1'b1;
            WriteRegister = 5'(n);
            #1;
            check($sformatf("en_comb_%0d", n), selectComb, refSel(1'b1, 5'(n)));
            tick();
            check($sformatf("en_reg_%0d", n), selectReg, refSel(1'b1, 5'(n)));
            if (n == 12) begin
                reset_n = 1'b0;
                #1;
                check("midreset_low", selectReg, 32'h0);
                #1;
                reset_n = 1'b1;
                #1;
                check("midreset_released_pre_edge", selectReg, 32'h0);
            end
        end
        if (!XzrMasked) check("bit31_unmasked", selectReg, 32'h8000_0000);
        else            check("bit31_masked", selectReg, 32'h0);

        // Random traffic against the reference, with one-hot checks.
        prevWe = RegWrite;
        prevAddr = WriteRegister;
        expPrev = refSel(prevWe, prevAddr);
        for (int i = 0; i < 1000; i++) begin
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom_range(0, 31));
            #1;
            check("rnd_comb", selectComb, refSel(RegWrite, WriteRegister));
            prevWe = RegWrite;
            prevAddr = WriteRegister;
            expPrev = refSel(prevWe, prevAddr);
            tick();
            check("rnd_reg", selectReg, expPrev);
            check("rnd_onehot", {31'b0, ($countones(selectReg) <= 1)}, 32'h1);
            if (!(XzrMasked && prevAddr == 5'd31))
                check("rnd_pop_eq_we", 32'($countones(selectReg)), {31'b0, prevWe});
        end

        // Submodule isolation: directed points then exhaustive.
        {d24I0, d24I1, d24En} = 3'b101;
        #1;
        check("d24_10_en", {28'b0, d24Out}, 32'h4);
        {d38I0, d38I1, d38I2, d38En} = 4'b1101;
        #1;
        check("d38_110_en", {24'b0, d38Out}, 32'h40);
        for (int v = 0; v < 8; v++) begin
            {d24I0, d24I1, d24En} = 3'(v);
            #1;
            check($sformatf("d24_%0d", v), {28'b0, d24Out},
                  d24En ? (32'h1 << ({30'b0, d24I0, d24I1})) : 32'h0);
        end
        for (int v = 0; v < 16; v++) begin
            {d38I0, d38I1, d38I2, d38En} = 4'(v);
            #1;
            check($sformatf("d38_%0d", v), {24'b0, d38Out},
                  d38En ? (32'h1 << ({29'b0, d38I0, d38I1, d38I2})) : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
